// File: rtl/phy_tx_idle_arbiter.sv
// Transmit gate: one idle check on CC per attempt, then backoff/retry, start, or fail,
// plus an inter-frame gap after each message. PHY_TX_RANDOM_BACKOFF_EN adds LFSR jitter.
module phy_tx_idle_arbiter #(
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned BACKOFF_CYCLES = 16,
    parameter int unsigned IFG_CYCLES     = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_req,
    input  logic       tx_abort,
    input  logic       tx_msg_done,
    input  logic       phy_definition_of_idle_done,
    input  logic       phy_definition_of_idle_result,
    output logic       phy_definition_of_idle_en,
    output logic       tx_start,
    output logic       tx_busy,
    output logic       tx_fail,
    output logic [2:0] retry_cnt
);

    // Backoff counter is wide enough for the jittered terminal count as well.
    localparam int unsigned BO_W  = $clog2(BACKOFF_CYCLES + 16) + 1;
    localparam int unsigned IFG_W = $clog2(IFG_CYCLES) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StBackoff,
        StStart,
        StXmit,
        StIfg,
        StFail
    } state_e;

    state_e            r_state;
    logic [2:0]        r_retry;
    logic              r_abort_pend;
    logic [BO_W-1:0]   r_bo_cnt;
    logic [IFG_W-1:0]  r_ifg_cnt;
    logic [BO_W-1:0]   w_bo_last;

`ifdef PHY_TX_RANDOM_BACKOFF_EN
    logic [7:0]        r_lfsr;
    logic [BO_W-1:0]   r_bo_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_bo_last = r_bo_last;
`else
    assign w_bo_last = BO_W'(BACKOFF_CYCLES - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_retry      <= '0;
            r_abort_pend <= 1'b0;
            r_bo_cnt     <= '0;
            r_ifg_cnt    <= '0;
`ifdef PHY_TX_RANDOM_BACKOFF_EN
            r_bo_last    <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (tx_abort) begin
                        r_retry <= '0;
                    end else if (tx_req) begin
                        r_state      <= StCheck;
                        r_retry      <= '0;
                        r_abort_pend <= 1'b0;
                    end
                end
                // The checker only clears its counters on done, so an abort waits for it.
                StCheck: begin
                    if (phy_definition_of_idle_done) begin
                        r_abort_pend <= 1'b0;
                        if (tx_abort || r_abort_pend) begin
                            r_state <= StIdle;
                        end else if (phy_definition_of_idle_result) begin
                            r_state <= StStart;
                        end else if (r_retry < 3'(MAX_RETRY)) begin
                            r_state  <= StBackoff;
                            r_retry  <= r_retry + 3'd1;
                            r_bo_cnt <= '0;
`ifdef PHY_TX_RANDOM_BACKOFF_EN
                            r_bo_last <= BO_W'(BACKOFF_CYCLES - 1) + BO_W'(r_lfsr[3:0]);
`endif
                        end else begin
                            r_state <= StFail;
                            if (r_retry != 3'd7) begin
                                r_retry <= r_retry + 3'd1;
                            end
                        end
                    end else if (tx_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                StBackoff: begin
                    if (tx_abort) begin
                        r_state <= StIdle;
                        r_retry <= '0;
                    end else if (r_bo_cnt == w_bo_last) begin
                        r_state <= StCheck;
                    end else begin
                        r_bo_cnt <= r_bo_cnt + 1'b1;
                    end
                end
                StStart: r_state <= StXmit;
                StXmit: begin
                    if (tx_msg_done) begin
                        r_state   <= StIfg;
                        r_ifg_cnt <= '0;
                    end
                end
                StIfg: begin
                    if (r_ifg_cnt == IFG_W'(IFG_CYCLES - 1)) begin
                        r_state <= StIdle;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + 1'b1;
                    end
                end
                StFail:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign phy_definition_of_idle_en = (r_state == StCheck);
    assign tx_start                  = (r_state == StStart);
    assign tx_fail                   = (r_state == StFail);
    assign tx_busy                   = (r_state != StIdle);
    assign retry_cnt                 = r_retry;

endmodule

// File: tb/tb_phy_tx_idle_arbiter.sv
// Bench for phy_tx_idle_arbiter: models the idle checker, drives random requests, and
// scoreboards tx_start/tx_fail events plus backoff and inter-frame gap lengths.
module tb_phy_tx_idle_arbiter;

    localparam int MAX_RETRY      = 3;
    localparam int BACKOFF_CYCLES = 16;
    localparam int IFG_CYCLES     = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_req = 1'b0;
    logic       tx_abort = 1'b0;
    logic       tx_msg_done = 1'b0;
    logic       idle_done = 1'b0;
    logic       idle_result = 1'b0;
    logic       idle_en;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_fail;
    logic [2:0] retry_cnt;

    always #5 clk = ~clk;

    phy_tx_idle_arbiter #(
        .MAX_RETRY      (MAX_RETRY),
        .BACKOFF_CYCLES (BACKOFF_CYCLES),
        .IFG_CYCLES     (IFG_CYCLES)
    ) u_dut (
        .clk                           (clk),
        .rst                           (rst),
        .tx_req                        (tx_req),
        .tx_abort                      (tx_abort),
        .tx_msg_done                   (tx_msg_done),
        .phy_definition_of_idle_done   (idle_done),
        .phy_definition_of_idle_result (idle_result),
        .phy_definition_of_idle_en     (idle_en),
        .tx_start                      (tx_start),
        .tx_busy                       (tx_busy),
        .tx_fail                       (tx_fail),
        .retry_cnt                     (retry_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit is_fail;
        int retry;
    } exp_t;

    exp_t q_exp[$];      // expected tx_start / tx_fail events, in order
    bit   q_res[$];      // line results the checker model returns, one per window
    int   cyc = 0;
    int   done_cyc = -10;
    int   win_fixed = 0; // 0: random window length
    bit   abort_active = 1'b0;
    bit   exp_gap_valid = 1'b0;
    int   busy_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Idle-checker model: answers each enable window after win_len cycles.
    initial begin : checker_model
        int en_cnt;
        int win_len;
        int gap;
        bit post_done;
        en_cnt = 0; win_len = 31; gap = 0; post_done = 1'b0;
        forever begin
            @(negedge clk);
            idle_done   = 1'b0;
            idle_result = 1'b0;
            if (post_done) begin
                check("en_low_after_done", int'(idle_en), 0);
                post_done = 1'b0;
                en_cnt    = 0;
                gap       = 1;
            end else if (idle_en === 1'b1) begin
                if (en_cnt == 0) begin
                    win_len = (win_fixed != 0) ? win_fixed : int'($urandom_range(31, 3));
                    if (exp_gap_valid) check("backoff_gap", gap, BACKOFF_CYCLES);
                    exp_gap_valid = 1'b0;
                end
                en_cnt++;
                if (en_cnt == win_len) begin
                    idle_done   = 1'b1;
                    idle_result = (q_res.size() > 0) ? q_res.pop_front() : 1'b1;
                    done_cyc    = cyc;
                    post_done   = 1'b1;
                    if (!idle_result) begin
                        busy_seen++;
                        exp_gap_valid = !abort_active && (busy_seen <= MAX_RETRY);
                    end
                end
            end else begin
                if (en_cnt != 0) check("en_dropped_before_done", en_cnt, 0);
                en_cnt = 0;
                gap++;
            end
        end
    end

    // Monitor: every start/fail pulse must match the next expected event.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 || tx_fail === 1'b1) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_event", int'({tx_fail, tx_start}), 0);
                end else begin
                    e = q_exp.pop_front();
                    check("event_kind", int'({tx_fail, tx_start}), e.is_fail ? 2 : 1);
                    check("event_retry_cnt", int'(retry_cnt), e.retry);
                    check("event_latency_after_done", cyc - done_cyc, 1);
                end
            end
        end
    end

    task automatic wait_en(input logic val, output bit ok);
        int n;
        n = 0;
        while (idle_en !== val && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 500);
        if (!ok) check("wait_en_timeout", int'(idle_en), int'(val));
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (tx_busy !== 1'b0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) check({name, "_timeout"}, int'(tx_busy), 0);
    endtask

    // amode: 0 none, 1 abort in first CHECK, 2 abort in first BACKOFF, 3 abort in XMIT
    task automatic run_txn(input int nbusy, input int amode, input int adelay,
                           input int msg_len, input bit hold_ifg);
        int n;
        bit ok;
        q_res.delete();
        for (int i = 0; i < nbusy; i++) q_res.push_back(1'b0);
        q_res.push_back(1'b1);
        busy_seen     = 0;
        exp_gap_valid = 1'b0;
        abort_active  = (amode == 1 || amode == 2);
        if (!abort_active) begin
            if (nbusy <= MAX_RETRY) q_exp.push_back('{is_fail: 1'b0, retry: nbusy});
            else                    q_exp.push_back('{is_fail: 1'b1, retry: MAX_RETRY + 1});
        end
        tx_req = 1'b1;
        if (abort_active) begin
            wait_en(1'b1, ok);
            if (!ok) begin tx_req = 1'b0; return; end
            if (amode == 2) begin
                wait_en(1'b0, ok);
                if (!ok) begin tx_req = 1'b0; return; end
            end
            repeat (adelay) @(negedge clk);
            tx_abort = 1'b1;
            tx_req   = 1'b0;
            @(negedge clk);
            tx_abort = 1'b0;
            if (amode == 2) begin
                check("abort_backoff_busy", int'(tx_busy), 0);
                check("abort_backoff_en", int'(idle_en), 0);
                check("abort_backoff_retry_cnt", int'(retry_cnt), 0);
            end else begin
                wait_idle("abort_check_idle", n);
            end
            return;
        end
        n = 0;
        while (!(tx_start === 1'b1 || tx_fail === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            check("start_or_fail_timeout", int'({tx_fail, tx_start}), 1);
            tx_req = 1'b0;
            return;
        end
        if (tx_fail === 1'b1) begin
            tx_req = 1'b0;
            wait_idle("after_fail_idle", n);
            return;
        end
        if (!hold_ifg) tx_req = 1'b0;
        for (int i = 0; i < msg_len; i++) begin
            @(negedge clk);
            tx_abort = (amode == 3 && i == 1);
        end
        tx_abort    = 1'b0;
        tx_msg_done = 1'b1;
        @(negedge clk);
        tx_msg_done = 1'b0;
        wait_idle("ifg_end", n);
        check("ifg_length", n, IFG_CYCLES);
        tx_req = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        repeat (2) @(negedge clk);
        check("reset_en", int'(idle_en), 0);
        check("reset_tx_start", int'(tx_start), 0);
        check("reset_tx_busy", int'(tx_busy), 0);
        check("reset_tx_fail", int'(tx_fail), 0);
        check("reset_retry_cnt", int'(retry_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        win_fixed = 31;
        run_txn(0, 0, 0, 100, 1'b0);
        run_txn(4, 0, 0, 10, 1'b0);
        run_txn(2, 0, 0, 10, 1'b0);
        run_txn(0, 1, 9, 10, 1'b0);
        run_txn(0, 3, 0, 20, 1'b1);
        win_fixed = 0;

        for (int t = 0; t < 40; t++) begin
            int nb;
            int am;
            int sel;
            nb  = $urandom_range(5, 0);
            sel = $urandom_range(5, 0);
            am  = (sel == 3) ? 1 : (sel == 4 && nb >= 1) ? 2 :
                  (sel == 5 && nb <= MAX_RETRY) ? 3 : 0;
            win_fixed = ($urandom_range(3, 0) == 0) ? 31 : 0;
            run_txn(nb, am, $urandom_range(2, 0), $urandom_range(40, 3), 1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) begin
                tx_msg_done = 1'b1;
                @(negedge clk);
                tx_msg_done = 1'b0;
                check("stray_msg_done_idle", int'(tx_busy), 0);
            end
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        win_fixed = 0;

        // Reset in the middle of a backoff: everything drops, no fail pulse follows.
        q_res.delete();
        for (int i = 0; i < 4; i++) q_res.push_back(1'b0);
        busy_seen     = 0;
        abort_active  = 1'b1;
        exp_gap_valid = 1'b0;
        tx_req        = 1'b1;
        wait_en(1'b1, ok);
        if (ok) wait_en(1'b0, ok);
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        tx_req = 1'b0;
        @(negedge clk);
        check("midrst_en", int'(idle_en), 0);
        check("midrst_tx_start", int'(tx_start), 0);
        check("midrst_tx_busy", int'(tx_busy), 0);
        check("midrst_tx_fail", int'(tx_fail), 0);
        check("midrst_retry_cnt", int'(retry_cnt), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_stays_idle", int'(tx_busy), 0);
        check("expected_events_left", q_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
